// File: rtl/filter2d_pkg.sv
// Shared types and sizing helpers for the filter2d AXI-Stream output stage.
package filter2d_pkg;

    localparam int unsigned TagWidth     = 3;
    localparam int unsigned DataWidthMax = 16;

    typedef struct packed {
        logic                    sof;
        logic                    eol;
        logic                    eof;
        logic [DataWidthMax-1:0] data;
    } pix_word_t;

    localparam int unsigned WordWidth = $bits(pix_word_t);

    // Counter width that stays legal for a one-entry range.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/filter2d_sync_fifo.sv
// Synchronous FIFO with a registered head word; level counts the head plus the backing ring.
module filter2d_sync_fifo #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               push,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               pop,
    output logic [WIDTH-1:0]   rdata,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LEVEL_W-1:0] level_q, level_d, mem_cnt;
    logic [WIDTH-1:0]   head_q, head_d;
    logic               head_vld_q, head_vld_d;
    logic               pop_ok, mem_wr, mem_rd;

    assign pop_ok  = pop && head_vld_q;
    assign mem_cnt = level_q - LEVEL_W'(head_vld_q);
    assign mem_rd  = pop_ok && (mem_cnt != '0);
    // A push bypasses the ring only when the head is free or being vacated with nothing behind it.
    assign mem_wr  = push && head_vld_q && !(pop_ok && (mem_cnt == '0));

    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        level_d    = level_q + LEVEL_W'(push) - LEVEL_W'(pop_ok);
        if (!head_vld_q) begin
            if (push) begin
                head_d     = wdata;
                head_vld_d = 1'b1;
            end
        end else if (pop_ok) begin
            if (mem_rd) begin
                head_d = mem_q[rd_ptr_q];
            end else if (push) begin
                head_d = wdata;
            end else begin
                head_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            level_q    <= level_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
            if (mem_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (mem_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_wr) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = head_q;
    assign empty = !head_vld_q;
    assign full  = (level_q == LEVEL_W'(DEPTH));
    assign level = level_q;

endmodule

// File: rtl/filter2d_axis_out.sv
// Saturates filter results, tags frame position and streams them out over AXI-Stream.
module filter2d_axis_out
    import filter2d_pkg::*;
#(
    parameter int unsigned FRAME_H    = 1080,
    parameter int unsigned FRAME_W    = 1920,
    parameter int unsigned DIN_WIDTH  = 10,
    parameter int unsigned DOUT_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic                          din_vld,
    input  logic [DIN_WIDTH-1:0]          din,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [DOUT_WIDTH-1:0]         m_tdata,
    output logic                          m_tuser,
    output logic                          m_tlast,
    output logic                          overflow,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned XW     = cnt_width(FRAME_W);
    localparam int unsigned YW     = cnt_width(FRAME_H);
    localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [XW-1:0]        XLast  = XW'(FRAME_W - 1);
    localparam logic [YW-1:0]        YLast  = YW'(FRAME_H - 1);
    localparam logic [DIN_WIDTH-1:0] SatMax = DIN_WIDTH'((2 ** DOUT_WIDTH) - 1);

    logic [XW-1:0]         x_q, x_d, tag_x;
    logic [YW-1:0]         y_q, y_d, tag_y;
    logic                  overflow_q, overflow_d, frame_done_q;
    logic                  push, pop, drop, fifo_full, fifo_empty;
    logic [DOUT_WIDTH-1:0] sat_pix;
    pix_word_t             wr_word, rd_word;
    logic                  unused_pad;

    assign pop  = !fifo_empty && m_tready;
    assign push = din_vld && (!fifo_full || pop);
    assign drop = din_vld && !push;

    always_comb begin
        // frame_start retargets a coincident pixel to (0,0).
        tag_x = frame_start ? '0 : x_q;
        tag_y = frame_start ? '0 : y_q;
        x_d   = x_q;
        y_d   = y_q;
        if (din_vld) begin
            if (tag_x == XLast) begin
                x_d = '0;
                y_d = (tag_y == YLast) ? '0 : tag_y + 1'b1;
            end else begin
                x_d = tag_x + 1'b1;
                y_d = tag_y;
            end
        end else if (frame_start) begin
            x_d = '0;
            y_d = '0;
        end
    end

    always_comb begin
        sat_pix      = (din > SatMax) ? '1 : din[DOUT_WIDTH-1:0];
        wr_word      = '0;
        wr_word.sof  = (tag_x == '0) && (tag_y == '0);
        wr_word.eol  = (tag_x == XLast);
        wr_word.eof  = (tag_x == XLast) && (tag_y == YLast);
        wr_word.data = DataWidthMax'(sat_pix);
    end

    // A drop wins over a coincident frame_start so the loss is never hidden.
    always_comb begin
        overflow_d = overflow_q;
        if (frame_start) overflow_d = 1'b0;
        if (drop)        overflow_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            overflow_q   <= overflow_d;
            frame_done_q <= pop && rd_word.eof;
        end
    end

    filter2d_sync_fifo #(
        .WIDTH   (WordWidth),
        .DEPTH   (FIFO_DEPTH),
        .LEVEL_W (LevelW)
    ) u_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (push),
        .wdata (wr_word),
        .pop   (pop),
        .rdata (rd_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign unused_pad = |(rd_word.data >> DOUT_WIDTH);

    assign m_tvalid   = !fifo_empty;
    assign m_tdata    = rd_word.data[DOUT_WIDTH-1:0];
    assign m_tuser    = rd_word.sof;
    assign m_tlast    = rd_word.eol;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_filter2d_axis_out.sv
// Directed bench for filter2d_axis_out with a queue-based reference model on a 4x3 frame.
module tb_filter2d_axis_out;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int DEPTH = 16;

    logic       clock = 1'b0;
    logic       rst, frame_start, din_vld, m_tready;
    logic [9:0] din;
    logic       m_tvalid, m_tuser, m_tlast, overflow, frame_done;
    logic [7:0] m_tdata;
    logic [4:0] fifo_level;

    always #5 clock = ~clock;

    filter2d_axis_out #(
        .FRAME_H    (H),
        .FRAME_W    (W),
        .DIN_WIDTH  (10),
        .DOUT_WIDTH (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .frame_start (frame_start),
        .din_vld     (din_vld),
        .din         (din),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tuser     (m_tuser),
        .m_tlast     (m_tlast),
        .overflow    (overflow),
        .frame_done  (frame_done),
        .fifo_level  (fifo_level)
    );

    typedef struct { logic [7:0] d; logic sof; logic eol; logic eof; } exp_t;
    typedef struct { logic [7:0] d; logic user; logic last; } obs_t;

    exp_t mq[$];
    obs_t out_log[$];
    int   mx = 0, my = 0, fd_count = 0;
    logic m_ov = 1'b0, m_fd = 1'b0, chk_en = 1'b0;
    int   n_checks = 0, n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: linear pixel index within the frame, a plain queue for the FIFO.
    always @(posedge clock) begin : model
        exp_t w;
        int   tx, ty, lin, sz;
        logic pop;
        if (rst) begin
            mq.delete();
            mx = 0; my = 0; m_ov = 1'b0; m_fd = 1'b0;
        end else begin
            sz   = mq.size();
            pop  = (sz > 0) && m_tready;
            m_fd = pop && mq[0].eof;
            tx   = frame_start ? 0 : mx;
            ty   = frame_start ? 0 : my;
            if (frame_start) m_ov = 1'b0;
            if (pop) void'(mq.pop_front());
            if (din_vld) begin
                w.d   = (din > 10'd255) ? 8'd255 : din[7:0];
                w.sof = (tx == 0) && (ty == 0);
                w.eol = (tx == W - 1);
                w.eof = (tx == W - 1) && (ty == H - 1);
                if (sz < DEPTH || pop) mq.push_back(w);
                else m_ov = 1'b1;
                lin = (ty * W + tx + 1) % (W * H);
                mx  = lin % W;
                my  = lin / W;
            end else if (frame_start) begin
                mx = 0; my = 0;
            end
        end
    end

    always @(negedge clock) begin : compare
        obs_t o;
        if (chk_en) begin
            chk("tvalid", m_tvalid, mq.size() > 0);
            chk("fifo_level", fifo_level, mq.size());
            chk("overflow", overflow, m_ov);
            chk("frame_done", frame_done, m_fd);
            if (mq.size() > 0 && m_tvalid) begin
                chk("tdata", m_tdata, mq[0].d);
                chk("tuser", m_tuser, mq[0].sof);
                chk("tlast", m_tlast, mq[0].eol);
            end
            if (m_tvalid && m_tready) begin
                o.d = m_tdata; o.user = m_tuser; o.last = m_tlast;
                out_log.push_back(o);
            end
            if (frame_done) fd_count++;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int d, input logic fs);
        din_vld = 1'b1; din = 10'(d); frame_start = fs;
        cyc();
        din_vld = 1'b0; frame_start = 1'b0;
    endtask

    initial begin
        int users;
        rst = 1'b1; din_vld = 1'b0; din = '0; frame_start = 1'b0; m_tready = 1'b1;
        cyc(); cyc();
        chk_en = 1'b1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 1'b0;

        // One full 4x3 frame, sink always ready.
        send(0, 1'b1);
        for (int i = 1; i < 12; i++) send(i, 1'b0);
        repeat (4) cyc();
        chk("frame_words", out_log.size(), 12);
        users = 0;
        foreach (out_log[i]) users += int'(out_log[i].user);
        chk("frame_user_count", users, 1);
        chk("frame_user0", out_log[0].user, 1);
        chk("frame_last2", out_log[2].last, 0);
        chk("frame_last3", out_log[3].last, 1);
        chk("frame_last7", out_log[7].last, 1);
        chk("frame_last11", out_log[11].last, 1);
        chk("frame_data11", out_log[11].d, 11);
        chk("frame_done_count", fd_count, 1);

        // Saturation.
        out_log.delete();
        send(255, 1'b0); send(256, 1'b0); send(1023, 1'b0); send(17, 1'b0);
        repeat (3) cyc();
        chk("sat_255", out_log[0].d, 255);
        chk("sat_256", out_log[1].d, 255);
        chk("sat_1023", out_log[2].d, 255);
        chk("sat_17", out_log[3].d, 17);

        // Backpressure: fill, push+pop at full, then a drop.
        out_log.delete();
        m_tready = 1'b0;
        send(0, 1'b1);
        for (int i = 1; i < 16; i++) send(i, 1'b0);
        chk("full_level", fifo_level, 16);
        chk("full_no_overflow", overflow, 0);
        m_tready = 1'b1; din_vld = 1'b1; din = 10'd100;
        cyc();
        din_vld = 1'b0; m_tready = 1'b0;
        chk("pushpop_level", fifo_level, 16);
        chk("pushpop_no_overflow", overflow, 0);
        send(101, 1'b0);
        chk("drop_overflow", overflow, 1);
        chk("drop_level", fifo_level, 16);
        m_tready = 1'b1;
        repeat (18) cyc();
        chk("drain_words", out_log.size(), 17);
        chk("drain_first", out_log[0].d, 0);
        chk("drain_15", out_log[15].d, 15);
        chk("drain_last", out_log[16].d, 100);
        chk("overflow_sticky", overflow, 1);
        chk("drain_level", fifo_level, 0);

        // frame_start mid-frame with queued words.
        out_log.delete();
        m_tready = 1'b0;
        for (int i = 50; i < 56; i++) send(i, 1'b0);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        chk("fs_clears_overflow", overflow, 0);
        send(56, 1'b0);
        m_tready = 1'b1;
        repeat (10) cyc();
        chk("fs_words", out_log.size(), 7);
        chk("fs_old0", out_log[0].d, 50);
        chk("fs_old0_user", out_log[0].user, 0);
        chk("fs_old1_last", out_log[1].last, 1);
        chk("fs_new_user", out_log[6].user, 1);
        chk("fs_new_data", out_log[6].d, 56);
        chk("fs_frame_done_count", fd_count, 3);

        // Reset with words queued, overriding a concurrent push and handshake.
        m_tready = 1'b0;
        for (int i = 60; i < 65; i++) send(i, 1'b0);
        chk("pre_rst_level", fifo_level, 5);
        rst = 1'b1; din_vld = 1'b1; din = 10'd99; m_tready = 1'b1;
        cyc();
        rst = 1'b0; din_vld = 1'b0;
        chk("post_rst_tvalid", m_tvalid, 0);
        chk("post_rst_level", fifo_level, 0);
        out_log.delete();
        send(77, 1'b0);
        repeat (3) cyc();
        chk("post_rst_words", out_log.size(), 1);
        chk("post_rst_data", out_log[0].d, 77);
        chk("post_rst_user", out_log[0].user, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
